pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Generates PC/IF_ID write enables, IF_ID/ID_EX flushes, EX_MEM hold and next-PC select from ID/EX hazard information, EX branch resolution (PCSrcB), data-memory wait and an external interrupt.
- Sequences interrupt entry: drain, then vector.
- Applies a bus-timeout watchdog on memory waits.

Parameters:
- DRAIN_CYCLES, 2: cycles the pipe drains after interrupt acceptance before vectoring (1..15).
- MEM_TIMEOUT, 255: consecutive mem_busy cycles that raise bus_err (1..2^WAIT_W-1).
- WAIT_W, 8: width of the wait counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_id_rs  in  5  Rs of the instruction in ID
- if_id_rt  in  5  Rt of the instruction in ID
- id_uses_rt  in  1  ID instruction reads Rt
- id_jump  in  1  ID holds j/jal/jr
- id_ex_memread  in  1  EX instruction is a load
- id_ex_rt  in  5  load destination in EX
- ex_branch_taken  in  1  PCSrcB from EX
- mem_busy  in  1  data memory/peripheral not ready this cycle
- irq  in  1  level interrupt request
- int_en  in  1  global interrupt enable
- irq_return  in  1  one-cycle pulse: handler return executed in EX
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF_ID register enable
- if_id_flush  out  1  IF_ID loads bubble
- id_ex_flush  out  1  ID_EX loads bubble
- ex_mem_hold  out  1  EX_MEM and MEM_WB hold
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 IRQ vector
- save_epc  out  1  core latches IF_ID PC into EPC
- irq_ack  out  1  one-cycle acknowledge on vectoring
- in_handler  out  1  interrupt handler active (registered)
- bus_err  out  1  one-cycle timeout pulse (registered)

Behaviour:
- Outputs are Mealy: combinational from state and inputs, except in_handler and bus_err, which are registered.
- Default, no event: pc_write=1, if_id_write=1, flushes=0, ex_mem_hold=0, pc_sel=00, save_epc=0, irq_ack=0.
- While reset=1:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_hold=0, pc_sel=00, irq_ack=0, save_epc=0.
  - Registers go to: state=RUN, drain_cnt=0, wait_cnt=0, in_handler=0, bus_err=0.
  - Reset overrides everything, including mid-drain.
- Memory freeze (highest priority, any state):
  - mem_busy=1 -> pc_write=0, if_id_write=0, ex_mem_hold=1, no flushes, pc_sel=00.
  - State and drain_cnt hold; wait_cnt increments.
  - When wait_cnt reaches MEM_TIMEOUT-1 with mem_busy=1: next cycle bus_err=1 and wait_cnt=0.
  - mem_busy=0 -> wait_cnt=0.
- FSM states: RUN, DRAIN, VECTOR.
- RUN, priority order (first match wins, mem_busy=0):
  1. ex_branch_taken: pc_sel=01, if_id_flush=1, id_ex_flush=1. Pending IRQ is deferred.
  2. irq & int_en & ~in_handler: save_epc=1, if_id_flush=1, id_ex_flush=1, pc_write=0; drain_cnt=DRAIN_CYCLES-1; next=DRAIN. Beats load-use and jump, because the flushed ID instruction is refetched via EPC.
  3. Load-use (id_ex_memread & id_ex_rt!=0 & (id_ex_rt==if_id_rs | (id_uses_rt & id_ex_rt==if_id_rt))): pc_write=0, if_id_write=0, id_ex_flush=1. Single-cycle bubble.
  4. id_jump: pc_sel=10, if_id_flush=1.
- DRAIN:
  - pc_write=0, if_id_flush=1, id_ex_flush=1.
  - drain_cnt decrements; at 0 -> VECTOR.
  - ex_branch_taken is ignored, since EX holds only bubbles.
- VECTOR (one cycle):
  - pc_sel=11, pc_write=1, if_id_flush=1, irq_ack=1, in_handler<=1; next=RUN.
  - If mem_busy=1, stays in VECTOR until clear.
- in_handler clears on irq_return (registered); irq_return has no effect when in_handler=0.
- irq arriving while in_handler=1 is held off (level) and is taken in the first RUN cycle after the clear.
- DRAIN_CYCLES=1 -> DRAIN lasts exactly one cycle.

Optional Feature:
- PIPE_HAZARD_PERF_EN defined adds two outputs:
  - stall_cnt[31:0]: cycles with pc_write=0 and reset=0.
  - flush_cnt[31:0]: cycles with id_ex_flush=1 and reset=0.
  - Both clear on reset and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- lw $8 in EX (id_ex_memread=1, id_ex_rt=8), ID reads rs=8 -> exactly 1 cycle pc_write=0, if_id_write=0, id_ex_flush=1; the following cycle is default.
- id_ex_rt=0 with matching rs=0 -> no stall; ex_branch_taken=1 and id_jump=1 in the same cycle -> pc_sel=01, both flushes=1.
- irq=1, int_en=1, DRAIN_CYCLES=2 -> cycle0: save_epc=1; cycles 1-2: DRAIN; cycle3: pc_sel=11, irq_ack=1; in_handler=1 from cycle4; second irq ignored until irq_return.
- mem_busy held 3 cycles during DRAIN -> outputs frozen, ex_mem_hold=1; VECTOR is delayed by exactly 3 cycles.
- MEM_TIMEOUT=4, mem_busy held 10 cycles -> bus_err pulses at cycles 5 and 9, counted from mem_busy rise at cycle 1; no pulse once mem_busy drops.
- Reset asserted in DRAIN -> next cycle state=RUN, in_handler=0, irq_ack never asserted.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard, flush and interrupt sequencing controller for the 5-stage pipeline.
//   Optional feature macro: PIPE_HAZARD_PERF_EN (adds stall_cnt / flush_cnt).
//   Inputs : clk, reset (sync, active-high), if_id_rs/if_id_rt/id_uses_rt/id_jump (ID info),
//            id_ex_memread/id_ex_rt (EX load info), ex_branch_taken, mem_busy,
//            irq, int_en, irq_return.
//   Outputs: pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, pc_sel[1:0],
//            save_epc, irq_ack (Mealy); in_handler, bus_err (registered).
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int WAIT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        id_uses_rt,
    input  logic        id_jump,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rt,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    input  logic        irq,
    input  logic        int_en,
    input  logic        irq_return,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_hold,
    output logic [1:0]  pc_sel,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        save_epc,
    output logic        irq_ack,
    output logic        in_handler,
    output logic        bus_err
);
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_VECTOR = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              in_handler_q, in_handler_d;
    logic              bus_err_q, bus_err_d;
    logic              load_use, irq_take;

    assign load_use = id_ex_memread && id_ex_rt != 5'd0 &&
                      (id_ex_rt == if_id_rs || (id_uses_rt && id_ex_rt == if_id_rt));
    assign irq_take = irq && int_en && !in_handler_q;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_hold  = 1'b0;
        pc_sel       = 2'b00;
        save_epc     = 1'b0;
        irq_ack      = 1'b0;
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        // Watchdog counts consecutive busy cycles, wrapping to zero on each timeout pulse
        bus_err_d    = mem_busy && wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1);
        wait_cnt_d   = (mem_busy && !bus_err_d) ? wait_cnt_q + WAIT_W'(1) : '0;
        in_handler_d = irq_return ? 1'b0 : in_handler_q;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (ex_branch_taken) begin
                        pc_sel      = 2'b01;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (irq_take) begin
                        // ID instruction is squashed and refetched from EPC after the handler
                        save_epc    = 1'b1;
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        drain_cnt_d = 4'(DRAIN_CYCLES - 1);
                        state_d     = S_DRAIN;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (id_jump) begin
                        pc_sel      = 2'b10;
                        if_id_flush = 1'b1;
                    end
                end
                S_DRAIN: begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = drain_cnt_q == 4'd0 ? S_VECTOR : S_DRAIN;
                    drain_cnt_d = drain_cnt_q == 4'd0 ? 4'd0 : drain_cnt_q - 4'd1;
                end
                S_VECTOR: begin
                    pc_sel       = 2'b11;
                    if_id_flush  = 1'b1;
                    irq_ack      = 1'b1;
                    in_handler_d = 1'b1;
                    state_d      = S_RUN;
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            drain_cnt_q  <= 4'd0;
            wait_cnt_q   <= '0;
            in_handler_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            in_handler_q <= in_handler_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign in_handler = in_handler_q;
    assign bus_err    = bus_err_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, !pc_write};
        flush_cnt_d = flush_cnt_q + {31'd0, id_ex_flush};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus against a behavioural model of the hazard controller.
module tb_pipeline_hazard_ctrl;
    localparam int DC = 2;
    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
    logic       id_uses_rt, id_jump, id_ex_memread, ex_branch_taken, mem_busy, irq, int_en, irq_return;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, save_epc, irq_ack;
    logic       in_handler, bus_err;
    logic [1:0] pc_sel;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] m_stall, m_flush;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .irq(irq), .int_en(int_en), .irq_return(irq_return),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold), .pc_sel(pc_sel),
`ifdef PIPE_HAZARD_PERF_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .save_epc(save_epc), .irq_ack(irq_ack), .in_handler(in_handler), .bus_err(bus_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Model: an interrupt in flight is "pending" with a count of drain cycles still owed;
    // the watchdog is tracked as the length of the current busy streak.
    bit m_pend, m_hand, m_berr;
    int m_left, m_streak;

    task automatic step();
        logic e_pcw, e_ifw, e_iff, e_idf, e_hold, e_epc, e_ack, lu;
        logic [1:0] e_sel;
        #1;
        {e_pcw, e_ifw} = 2'b11;
        {e_iff, e_idf, e_hold, e_epc, e_ack} = '0;
        e_sel = 2'b00;
        lu = id_ex_memread && id_ex_rt != 0 &&
             (id_ex_rt == if_id_rs || (id_uses_rt && id_ex_rt == if_id_rt));
        if (reset) begin
            {e_pcw, e_ifw, e_iff, e_idf} = 4'b0011;
        end else if (mem_busy) begin
            {e_pcw, e_ifw, e_hold} = 3'b001;
        end else if (m_pend && m_left > 0) begin
            {e_pcw, e_iff, e_idf} = 3'b011;
        end else if (m_pend) begin
            e_sel = 2'b11; e_iff = 1; e_ack = 1;
        end else if (ex_branch_taken) begin
            e_sel = 2'b01; e_iff = 1; e_idf = 1;
        end else if (irq && int_en && !m_hand) begin
            e_epc = 1; e_iff = 1; e_idf = 1; e_pcw = 0;
        end else if (lu) begin
            {e_pcw, e_ifw, e_idf} = 3'b001;
        end else if (id_jump) begin
            e_sel = 2'b10; e_iff = 1;
        end
        check("ctl", {23'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, pc_sel, save_epc, irq_ack},
                     {23'd0, e_pcw, e_ifw, e_iff, e_idf, e_hold, e_sel, e_epc, e_ack});
        check("in_handler", {31'd0, in_handler}, {31'd0, m_hand});
        check("bus_err", {31'd0, bus_err}, {31'd0, m_berr});
`ifdef PIPE_HAZARD_PERF_EN
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
`endif
        if (reset) begin
            m_pend = 0; m_hand = 0; m_berr = 0; m_left = 0; m_streak = 0;
`ifdef PIPE_HAZARD_PERF_EN
            m_stall = 0; m_flush = 0;
`endif
        end else begin
`ifdef PIPE_HAZARD_PERF_EN
            m_stall += {31'd0, !e_pcw};
            m_flush += {31'd0, e_idf};
`endif
            m_berr = mem_busy && ((m_streak + 1) % MT == 0);
            m_streak = mem_busy ? m_streak + 1 : 0;
            if (e_ack) begin
                m_pend = 0; m_hand = 1;
            end else begin
                if (irq_return) m_hand = 0;
                if (!mem_busy && m_pend) m_left--;
                if (e_epc) begin m_pend = 1; m_left = DC; end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        {reset, id_uses_rt, id_jump, id_ex_memread, ex_branch_taken, mem_busy, irq, irq_return} = '0;
        int_en = 1; if_id_rs = 0; if_id_rt = 0; id_ex_rt = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        m_pend = 0; m_hand = 0; m_berr = 0; m_left = 0; m_streak = 0;
`ifdef PIPE_HAZARD_PERF_EN
        m_stall = 0; m_flush = 0;
`endif
        idle(); reset = 1;
        @(negedge clk);
        steps(2);
        reset = 0;
        steps(1);
        // load-use: lw $8 in EX, ID reads $8
        id_ex_memread = 1; id_ex_rt = 8; if_id_rs = 8; step();
        idle(); step();
        // $0 destination never stalls; branch beats jump
        id_ex_memread = 1; id_ex_rt = 0; if_id_rs = 0; step();
        idle(); ex_branch_taken = 1; id_jump = 1; step();
        idle(); id_jump = 1; step();
        // interrupt entry, held-off second irq, return, retake
        idle(); irq = 1; steps(8);
        irq_return = 1; step();
        irq_return = 0; step();
        irq = 0; steps(5);
        irq_return = 1; step(); irq_return = 0; step();
        // mem_busy during DRAIN delays the vector
        irq = 1; step(); irq = 0; step();
        mem_busy = 1; steps(3); mem_busy = 0; steps(3);
        irq_return = 1; step(); irq_return = 0;
        // watchdog
        mem_busy = 1; steps(10); mem_busy = 0; steps(3);
        // reset mid-drain
        irq = 1; step(); irq = 0; step();
        reset = 1; step(); reset = 0; steps(4);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            mem_busy        = ($urandom_range(0, 5) == 0) || (mem_busy && $urandom_range(0, 3) != 0);
            irq             = ($urandom_range(0, 3) == 0);
            int_en          = ($urandom_range(0, 3) != 0);
            irq_return      = ($urandom_range(0, 19) == 0);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            id_jump         = ($urandom_range(0, 5) == 0);
            id_ex_memread   = ($urandom_range(0, 2) == 0);
            id_uses_rt      = $urandom_range(0, 1) == 1;
            if_id_rs        = 5'($urandom_range(0, 3));
            if_id_rt        = 5'($urandom_range(0, 3));
            id_ex_rt        = 5'($urandom_range(0, 3));
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
